// File: rtl/dmem_mmio_pkg.sv
// Shared bus constants and access classification for the MEM-stage data responder.
package dmem_mmio_pkg;
  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam int MmioSelBit = 31;
  localparam int SwitchNum  = 16;
  localparam int LedNum     = 16;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RAM,
    ACC_MMIO
  } acc_e;

  function automatic logic is_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction
endpackage

// File: rtl/dmem_mmio_debounce.sv
// Synchronizes and debounces the raw switch vector as a single unit.
module switch_debounce #(
  parameter int SWITCH_NUM      = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SWITCH_NUM-1:0] sw_i,
  output logic [SWITCH_NUM-1:0] stable_o
);
  localparam int CntW = $clog2(DEBOUNCE_CYCLES);

  logic [SWITCH_NUM-1:0] s1_q, s2_q, s3_q, stable_q, stable_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  // Any movement between s2 and s3 restarts the stability window.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s2_q != s3_q) begin
      cnt_d = '0;
    end else if (s2_q != stable_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= sw_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/dmem_mmio.sv
// MEM-stage data responder: word RAM below bit 31, LED/switch MMIO window above it.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int SWITCH_NUM      = SwitchNum,
  parameter int LED_NUM         = LedNum,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic                  we_i,
  input  logic [RegBus-1:0]     addr_i,
  input  logic [RegBus-1:0]     data_i,
  output logic [RegBus-1:0]     data_o,
  input  logic [SWITCH_NUM-1:0] switch_i,
  output logic [LED_NUM-1:0]    led_o,
  output logic                  err_o
);
  localparam int Depth = 2 ** ADDR_WIDTH;

  logic [RegBus-1:0]     mem_q [Depth];
  logic [ADDR_WIDTH-1:0] idx;
  acc_e                  acc;
  logic                  misalign, ram_we, led_we;
  logic [LED_NUM-1:0]    led_q, led_d;
  logic                  err_q, err_d;
  logic [SWITCH_NUM-1:0] sw_stable;
  logic                  unused_bits;

  // Upper RAM address bits alias; they only feed this sink.
  assign unused_bits = ^{addr_i, data_i};
  assign idx         = addr_i[ADDR_WIDTH+1:2];

  always_comb begin
    if (addr_i[MmioSelBit])        acc = ACC_MMIO;
    else if (ce_i == ChipDisable)  acc = ACC_IDLE;
    else                           acc = ACC_RAM;
  end

  assign misalign = (acc != ACC_IDLE) && is_misaligned(addr_i[1:0]);
  assign ram_we   = rst && (acc == ACC_RAM)  && (we_i == WriteEnable) && !misalign;
  assign led_we   = (acc == ACC_MMIO) && (we_i == WriteEnable) && !misalign;
  assign led_d    = led_we ? data_i[LED_NUM-1:0] : led_q;
  assign err_d    = err_q | misalign;

  // Load path is combinational: the MEM stage consumes data in the same cycle.
  always_comb begin
    data_o = ZeroWord;
    if (rst && (we_i == WriteDisable)) begin
      case (acc)
        ACC_RAM:  data_o = mem_q[idx];
        ACC_MMIO: data_o = RegBus'(sw_stable);
        default:  data_o = ZeroWord;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem_q[idx] <= data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q <= '0;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      err_q <= err_d;
    end
  end

  assign led_o = led_q;
  assign err_o = err_q;

  switch_debounce #(
    .SWITCH_NUM      (SWITCH_NUM),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .sw_i     (switch_i),
    .stable_o (sw_stable)
  );
endmodule

// File: tb/tb_dmem_mmio.sv
// Directed scoreboard bench for dmem_mmio with a short debounce window.
module tb_dmem_mmio;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [31:0] addr_i, data_i, data_o;
  logic [15:0] switch_i, led_o;
  logic        err_o;

  int n_pass   = 0;
  int n_checks = 0;
  logic [31:0] exp_q [$];

  dmem_mmio #(
    .ADDR_WIDTH      (10),
    .SWITCH_NUM      (16),
    .LED_NUM         (16),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (ce_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .data_o   (data_o),
    .switch_i (switch_i),
    .led_o    (led_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: observed %h but scoreboard is empty", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic ce, input logic [31:0] ev,
                      input string tag);
    ce_i = ce; we_i = 1'b0; addr_i = a;
    sb_push(ev);
    #1;
    sb_check(tag, data_o);
  endtask

  task automatic store(input logic [31:0] a, input logic ce, input logic [31:0] d);
    ce_i = ce; we_i = 1'b1; addr_i = a; data_i = d;
    sb_push(32'h0);
    #1;
    sb_check("store_data_o_zero", data_o);
  endtask

  initial begin
    rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0; switch_i = '0;
    #2;
    load(32'h0000_0010, 1'b1, 32'h0, "rst_data_o");
    sb_push(32'h0); sb_check("rst_led", 32'(led_o));
    sb_push(32'h0); sb_check("rst_err", 32'(err_o));
    step();
    rst = 1'b1;

    store(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
    step();
    load(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, "ram_read");
    load(32'h0000_1010, 1'b1, 32'hDEAD_BEEF, "ram_alias");
    load(32'h0000_0010, 1'b0, 32'h0, "ram_ce_off");
    store(32'h0000_0000, 1'b1, 32'h1111_2222);
    step();

    store(32'h8000_0000, 1'b0, 32'h1234_A5A5);
    sb_push(32'h0); sb_check("led_before_edge", 32'(led_o));
    step();
    sb_push(32'h0000_A5A5); sb_check("led_after_store", 32'(led_o));
    load(32'h0000_0000, 1'b1, 32'h1111_2222, "ram0_untouched");
    sb_push(32'h0); sb_check("err_clean", 32'(err_o));

    store(32'h0000_0012, 1'b1, 32'hCAFE_F00D);
    step();
    sb_push(32'h1); sb_check("err_set", 32'(err_o));
    load(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, "word4_kept");
    load(32'h0000_0012, 1'b1, 32'hDEAD_BEEF, "misaligned_load");
    step();
    store(32'h8000_0002, 1'b0, 32'h0000_FFFF);
    step();
    sb_push(32'h0000_A5A5); sb_check("led_misaligned_kept", 32'(led_o));
    sb_push(32'h1); sb_check("err_sticky", 32'(err_o));

    rst = 1'b0;
    load(32'h0000_0010, 1'b1, 32'h0, "async_rst_data_o");
    sb_push(32'h0); sb_check("async_rst_err", 32'(err_o));
    sb_push(32'h0); sb_check("async_rst_led", 32'(led_o));
    rst = 1'b1;

    // Short pulse must not get through the debouncer.
    step();
    switch_i = 16'h0003;
    ce_i = 1'b0; we_i = 1'b0; addr_i = 32'h8000_0000;
    repeat (3) step();
    switch_i = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      step();
      load(32'h8000_0000, 1'b0, 32'h0, "pulse_rejected");
    end

    // Held input appears exactly DB+2 edges after the first sampling edge.
    switch_i = 16'h0003;
    for (int k = 0; k <= DB + 2; k++) begin
      step();
      load(32'h8000_0000, 1'b0, (k >= DB + 2) ? 32'h3 : 32'h0, "debounce_hold");
    end

    switch_i = 16'h0000;
    rst = 1'b0; #1; rst = 1'b1;
    step();
    switch_i = 16'h0005;
    for (int k = 0; k <= 4; k++) begin
      step();
      load(32'h8000_0000, 1'b0, 32'h0, "pre_reset_window");
    end
    rst = 1'b0;
    load(32'h8000_0000, 1'b0, 32'h0, "mid_debounce_reset");
    rst = 1'b1;
    for (int k = 5; k <= 5 + DB + 2; k++) begin
      step();
      load(32'h8000_0000, 1'b0, (k >= 5 + DB + 2) ? 32'h5 : 32'h0, "restart_after_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
